neopixel_strip_ctrl: RTL and testbench

NEOPIXEL_STRIP_CTRL -- requirements
Module: neopixel_strip_ctrl

---
 rtl/neopixel_strip_ctrl.sv | 170 +++++++++++++++++
 tb/tb_neopixel_strip_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/neopixel_strip_ctrl.sv
// WS2812 strip driver: pixel buffer, per-bit HIGH/LOW timing, latch gap,
// coalesced frame requests and optional periodic auto-refresh.
module neopixel_strip_ctrl #(
  parameter int NUM_LEDS       = 8,
  parameter int PX_BITS        = 24,
  parameter int T0H            = 25,
  parameter int T1H            = 50,
  parameter int T_BIT          = 90,
  parameter int T_LATCH        = 5760,
  parameter int REFRESH_CYCLES = 72_000_000,
  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic               axi_clk,
  input  logic               axi_reset,
  input  logic               i_wr_en,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [PX_BITS-1:0] i_wr_data,
  input  logic               i_start,
  output logic               o_serial,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic [3:0]         o_debug
);

  localparam int TMAX = (T_LATCH > T_BIT) ? T_LATCH : T_BIT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(PX_BITS);
  localparam int RW   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [TW-1:0] T1H_M1   = TW'(T1H - 1);
  localparam logic [TW-1:0] T0H_M1   = TW'(T0H - 1);
  localparam logic [TW-1:0] LOW1_M1  = TW'(T_BIT - T1H - 1);
  localparam logic [TW-1:0] LOW0_M1  = TW'(T_BIT - T0H - 1);
  localparam logic [TW-1:0] LATCH_M1 = TW'(T_LATCH - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_LEDS - 1);
  localparam logic [AW:0]   NUM_W    = (AW + 1)'(NUM_LEDS);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic          REF_EN   = (REFRESH_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_LATCH = 3'd4
  } state_t;

  state_t             state_r;
  logic [PX_BITS-1:0] buf_r [2**AW];
  logic [PX_BITS-1:0] shift_r;
  logic [BW-1:0]      bit_cnt_r;
  logic [AW-1:0]      idx_r;
  logic [TW-1:0]      timer_r;
  logic [RW-1:0]      ref_cnt_r;
  logic               pending_r;
  logic               refresh_exp_s;
  logic               last_short_s;

  function automatic logic [TW-1:0] high_m1(input logic msb);
    return msb ? T1H_M1 : T0H_M1;
  endfunction

  // Last bit of a non-final pixel gives one LOW clock to the following LOAD.
  function automatic logic [TW-1:0] low_m1(input logic msb, input logic shorten);
    logic [TW-1:0] base;
    base = msb ? LOW1_M1 : LOW0_M1;
    return shorten ? (base - TW'(1)) : base;
  endfunction

  assign refresh_exp_s = REF_EN && (ref_cnt_r == REF_LAST);
  assign last_short_s  = (bit_cnt_r == BW'(0)) && (idx_r != LAST_IDX);
  assign o_debug       = {pending_r, state_r};

  // Pixel buffer: writable in every state, out-of-range addresses dropped.
  always_ff @(posedge axi_clk or negedge axi_reset) begin
    if (!axi_reset) begin
      for (int i = 0; i < 2**AW; i++) buf_r[i] <= {PX_BITS{1'b0}};
    end else if (i_wr_en && ({1'b0, i_wr_addr} < NUM_W)) begin
      buf_r[i_wr_addr] <= i_wr_data;
    end
  end

  // Frame FSM with registered serial/busy/done outputs.
  always_ff @(posedge axi_clk or negedge axi_reset) begin
    if (!axi_reset) begin
      state_r      <= S_IDLE;
      shift_r      <= {PX_BITS{1'b0}};
      bit_cnt_r    <= BW'(0);
      idx_r        <= AW'(0);
      timer_r      <= TW'(0);
      ref_cnt_r    <= RW'(0);
      pending_r    <= 1'b0;
      o_serial     <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (i_start && o_busy) pending_r <= 1'b1;
      case (state_r)
        S_IDLE: begin
          if (i_start || pending_r || refresh_exp_s) begin
            state_r   <= S_LOAD;
            idx_r     <= AW'(0);
            o_busy    <= 1'b1;
            ref_cnt_r <= RW'(0);
            pending_r <= 1'b0;
          end else if (REF_EN) begin
            ref_cnt_r <= ref_cnt_r + RW'(1);
          end
        end
        S_LOAD: begin
          shift_r   <= buf_r[idx_r];
          bit_cnt_r <= BW'(PX_BITS - 1);
          timer_r   <= high_m1(buf_r[idx_r][PX_BITS-1]);
          o_serial  <= 1'b1;
          state_r   <= S_HIGH;
        end
        S_HIGH: begin
          if (timer_r == TW'(0)) begin
            o_serial <= 1'b0;
            timer_r  <= low_m1(shift_r[PX_BITS-1], last_short_s);
            state_r  <= S_LOW;
          end else begin
            timer_r <= timer_r - TW'(1);
          end
        end
        S_LOW: begin
          if (timer_r != TW'(0)) begin
            timer_r <= timer_r - TW'(1);
          end else if (bit_cnt_r != BW'(0)) begin
            shift_r   <= {shift_r[PX_BITS-2:0], 1'b0};
            bit_cnt_r <= bit_cnt_r - BW'(1);
            timer_r   <= high_m1(shift_r[PX_BITS-2]);
            o_serial  <= 1'b1;
            state_r   <= S_HIGH;
          end else if (idx_r != LAST_IDX) begin
            idx_r   <= idx_r + AW'(1);
            state_r <= S_LOAD;
          end else begin
            timer_r <= LATCH_M1;
            state_r <= S_LATCH;
          end
        end
        S_LATCH: begin
          if (timer_r != TW'(0)) begin
            timer_r <= timer_r - TW'(1);
          end else begin
            o_frame_done <= 1'b1;
            ref_cnt_r    <= RW'(0);
            // A request seen during the frame (or right now) chains the next frame.
            if (pending_r || i_start) begin
              state_r   <= S_LOAD;
              idx_r     <= AW'(0);
              pending_r <= 1'b0;
            end else begin
              state_r <= S_IDLE;
              o_busy  <= 1'b0;
            end
          end
        end
        default: begin
          state_r  <= S_IDLE;
          o_serial <= 1'b0;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_strip_ctrl.sv
// Directed bench: 2x24 default-timing strip plus a 1x32 fast-timing strip with auto-refresh.
module tb_neopixel_strip_ctrl;

  logic axi_clk = 1'b0;
  logic axi_reset = 1'b0;
  always #5 axi_clk = ~axi_clk;

  logic        wr_en1 = 1'b0, addr1 = 1'b0, start1 = 1'b0;
  logic [23:0] wdata1 = 24'h0;
  logic        ser1, busy1, done1;
  logic [3:0]  dbg1;

  logic        wr_en2 = 1'b0, addr2 = 1'b0, start2 = 1'b0;
  logic [31:0] wdata2 = 32'h0;
  logic        ser2, busy2, done2;
  logic [3:0]  dbg2;

  logic sel = 1'b0;
  logic ser_m, done_m;
  assign ser_m  = sel ? ser2 : ser1;
  assign done_m = sel ? done2 : done1;

  int vectors = 0;
  int miscompares = 0;

  neopixel_strip_ctrl #(.NUM_LEDS(2), .REFRESH_CYCLES(0)) dut1 (
    .axi_clk(axi_clk), .axi_reset(axi_reset), .i_wr_en(wr_en1), .i_wr_addr(addr1),
    .i_wr_data(wdata1), .i_start(start1), .o_serial(ser1), .o_busy(busy1),
    .o_frame_done(done1), .o_debug(dbg1));

  neopixel_strip_ctrl #(.NUM_LEDS(1), .PX_BITS(32), .T0H(2), .T1H(4), .T_BIT(8),
                        .T_LATCH(10), .REFRESH_CYCLES(100)) dut2 (
    .axi_clk(axi_clk), .axi_reset(axi_reset), .i_wr_en(wr_en2), .i_wr_addr(addr2),
    .i_wr_data(wdata2), .i_start(start2), .o_serial(ser2), .o_busy(busy2),
    .o_frame_done(done2), .o_debug(dbg2));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic wr1(input logic a, input logic [23:0] d);
    wr_en1 = 1'b1; addr1 = a; wdata1 = d;
    tick();
    wr_en1 = 1'b0;
  endtask

  // Mid-frame stimulus: rewrite pixel 1 and fire three extra start requests.
  task automatic side_drive(input int h);
    case (h)
      0: begin wr_en1 = 1'b1; addr1 = 1'b1; wdata1 = 24'hFFFFFF; start1 = 1'b1; end
      1: begin wr_en1 = 1'b0; start1 = 1'b0; end
      3: start1 = 1'b1;
      4: start1 = 1'b0;
      6: start1 = 1'b1;
      7: start1 = 1'b0;
      8: check_val("pending_set", dbg1[3], 1);
      default: ;
    endcase
  endtask

  // Called just after the start edge; measures every bit and the frame length.
  task automatic measure_frame(input logic [47:0] bits, input int nbits, input int th1,
                               input int th0, input int tbit, input int flen, input bit act);
    int t, h, l;
    bit lost;
    t = 0; lost = 1'b0;
    tick(); t++;
    check_val("first_high", ser_m, 1);
    for (int b = 0; b < nbits && !lost; b++) begin
      h = 0;
      while (ser_m === 1'b1 && h < 200) begin
        if (act && b == 2) side_drive(h);
        tick(); h++; t++;
      end
      check_val("high_time", h, bits[nbits-1-b] ? th1 : th0);
      l = 0;
      while (ser_m !== 1'b1 && done_m !== 1'b1 && l < 7000) begin
        tick(); l++; t++;
      end
      if (l >= 7000) lost = 1'b1;
      if (b < nbits - 1) check_val("bit_period", h + l, tbit);
    end
    check_val("frame_len", t, flen);
    check_val("done_pulse", done_m, 1);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rises;
    logic prev;

    #12;
    check_val("rst_serial", ser1, 0);
    check_val("rst_busy", busy1, 0);
    check_val("rst_done", done1, 0);
    check_val("rst_debug", dbg1, 0);
    #11 axi_reset = 1'b1;

    // Fast strip: load pixel, poke the out-of-range address, wait for auto-refresh.
    n = 0;
    while (busy2 !== 1'b1 && n < 300) begin
      case (n)
        0: begin wr_en2 = 1'b1; addr2 = 1'b0; wdata2 = 32'h00000001; end
        1: begin addr2 = 1'b1; wdata2 = 32'hFFFFFFFF; end
        default: wr_en2 = 1'b0;
      endcase
      tick(); n++;
    end
    wr_en2 = 1'b0;
    check_val("refresh_first", n, 100);
    check_val("dbg2_load", dbg2, 1);
    sel = 1'b1;
    measure_frame({16'h0, 32'h00000001}, 32, 4, 2, 8, 267, 1'b0);
    n = 0;
    while (busy2 !== 1'b1 && n < 300) begin tick(); n++; end
    check_val("refresh_gap", n, 100);
    sel = 1'b0;

    // Frame A: reference pattern.
    wr1(1'b0, 24'h800001);
    wr1(1'b1, 24'h000000);
    start1 = 1'b1; tick(); start1 = 1'b0;
    check_val("busy_rise", busy1, 1);
    check_val("serial_lat", ser1, 0);
    check_val("dbg_load", dbg1, 1);
    measure_frame({24'h800001, 24'h000000}, 48, 50, 25, 90, 10081, 1'b0);
    check_val("busy_end", busy1, 0);
    tick();
    check_val("done_one_cycle", done1, 0);
    check_val("dbg_idle", dbg1, 0);

    // Frame B with mid-frame write and extra requests, then exactly one chained frame C.
    start1 = 1'b1; tick(); start1 = 1'b0;
    measure_frame({24'h800001, 24'hFFFFFF}, 48, 50, 25, 90, 10081, 1'b1);
    check_val("chain_busy", busy1, 1);
    check_val("chain_dbg", dbg1, 1);
    measure_frame({24'h800001, 24'hFFFFFF}, 48, 50, 25, 90, 10081, 1'b0);
    check_val("after_c_dbg", dbg1, 0);
    rises = 0; prev = busy1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (busy1 === 1'b1 && prev !== 1'b1) rises++;
      prev = busy1;
    end
    check_val("no_extra_frame", rises, 0);

    // Reset in the middle of pixel 1, bit 0 HIGH.
    start1 = 1'b1; tick(); start1 = 1'b0;
    repeat (1 + 2160 + 30) tick();
    check_val("pre_reset_high", ser1, 1);
    #3 axi_reset = 1'b0;
    #1;
    check_val("rst_mid_serial", ser1, 0);
    check_val("rst_mid_busy", busy1, 0);
    check_val("rst_mid_dbg", dbg1, 0);
    #10 axi_reset = 1'b1;
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy1 === 1'b1) rises++;
    end
    check_val("no_resume", rises, 0);

    // Buffer must read back as zero after reset.
    start1 = 1'b1; tick(); start1 = 1'b0;
    measure_frame(48'h0, 48, 50, 25, 90, 10081, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
